// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks: default operand width,
// reduction timing and the modular-exponentiation FSM state encoding.
package rsa_pkg;

    localparam int unsigned W_DEFAULT  = 8;
    localparam int unsigned RED_CYCLES = 2 * W_DEFAULT + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RED_B,
        S_TEST,
        S_MUL_A,
        S_SQR_B,
        S_DONE
    } mexp_state_e;

endpackage

// File: rtl/mod_exp_unit_if.sv
// Request/status bundle between the RSA control FSM (master) and the
// modular-exponentiation engine (slave).
interface mod_exp_unit_if #(
    parameter int unsigned W = rsa_pkg::W_DEFAULT
);

    logic         start;
    logic [W-1:0] base;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, err, result
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, err, result
    );

endinterface

// File: rtl/mod_reduce_seq.sv
// Restoring shift-subtract reducer: rem = prod mod n, one product bit per
// cycle MSB first, 1 load cycle plus 2W iterations per reduction.
module mod_reduce_seq
    import rsa_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           go,
    input  logic [2*W-1:0] prod,
    input  logic [W-1:0]   n,
    output logic [W-1:0]   rem,
    output logic           rdy
);

    localparam int unsigned CW = $clog2(2 * W + 1);

    logic           active_q, active_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   n_q, n_d;
    logic [W:0]     r_shift;
    logic [W:0]     diff;
    logic [W-1:0]   r_step;

    // r < n keeps r_shift below 2n, so a borrow in diff means r_shift < n
    always_comb begin
        r_shift = {r_q, p_q[2*W-1]};
        diff    = r_shift - {1'b0, n_q};
        r_step  = diff[W] ? r_shift[W-1:0] : diff[W-1:0];
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        r_d      = r_q;
        n_d      = n_q;
        rdy      = 1'b0;
        if (active_q) begin
            r_d   = r_step;
            p_d   = p_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                active_d = 1'b0;
                rdy      = 1'b1;
            end
        end else if (go) begin
            active_d = 1'b1;
            p_d      = prod;
            n_d      = n;
            r_d      = '0;
            cnt_d    = CW'(2 * W);
        end
    end

    // Result is presented combinationally on the last iteration so the
    // caller can capture it on the same edge that ends the reduction.
    assign rem = r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            r_q      <= '0;
            n_q      <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            r_q      <= r_d;
            n_q      <= n_d;
        end
    end

endmodule

// File: rtl/mod_exp_unit.sv
// Sequential right-to-left square-and-multiply engine computing
// base^exponent mod modulus with one shared multiplier and one reducer.
module mod_exp_unit
    import rsa_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    mod_exp_unit_if.slave bus
);

    mexp_state_e    state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   e_q, e_d;
    logic [W-1:0]   n_q, n_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;

    logic           red_go;
    logic           red_rdy;
    logic [W-1:0]   red_rem;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_a;

    mod_reduce_seq #(.W(W)) u_reduce (
        .clk   (clk),
        .reset (reset),
        .go    (red_go),
        .prod  (prod),
        .n     (n_q),
        .rem   (red_rem),
        .rdy   (red_rdy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            e_q      <= e_d;
            n_q      <= n_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        e_d      = e_q;
        n_d      = n_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    b_d     = bus.base;
                    e_d     = bus.exponent;
                    n_d     = bus.modulus;
                    acc_d   = W'(1);
                    err_d   = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (n_q == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (n_q == W'(1)) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (e_q == '0) begin
                    result_d = W'(1);
                    state_d  = S_DONE;
                end else begin
                    state_d = S_RED_B;
                end
            end
            S_RED_B: begin
                if (red_rdy) begin
                    b_d     = red_rem;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                state_d = e_q[0] ? S_MUL_A : S_SQR_B;
            end
            S_MUL_A: begin
                if (red_rdy) begin
                    acc_d   = red_rem;
                    state_d = S_SQR_B;
                end
            end
            S_SQR_B: begin
                if (red_rdy) begin
                    b_d = red_rem;
                    e_d = e_q >> 1;
                    if (e_q[W-1:1] == '0) begin
                        result_d = acc_q;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_TEST;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.done = (state_q == S_DONE);
        red_go   = (state_q == S_RED_B) || (state_q == S_MUL_A) || (state_q == S_SQR_B);
        mul_a    = (state_q == S_MUL_A) ? acc_q : b_q;
        if (state_q == S_RED_B) begin
            prod = {{W{1'b0}}, b_q};
        end else begin
            prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, b_q};
        end
    end

    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Directed and randomized checks of mod_exp_unit against a naive
// repeated-multiplication reference with a closed-form latency model.
module tb_mod_exp_unit;

    localparam int unsigned W = 8;
    localparam int unsigned TIMEOUT = 3000;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mod_exp_unit_if #(.W(W)) bus ();

    mod_exp_unit #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void ref_model(input int unsigned b, input int unsigned e,
                                      input int unsigned m, output int unsigned res,
                                      output bit er, output int unsigned lat);
        int unsigned k;
        int unsigned tmp;
        er  = 1'b0;
        lat = 3;
        if (m == 0) begin
            er  = 1'b1;
            res = 0;
        end else if (m == 1) begin
            res = 0;
        end else if (e == 0) begin
            res = 1;
        end else begin
            res = 1;
            for (int unsigned i = 0; i < e; i++) res = (res * b) % m;
            k   = 0;
            tmp = e;
            while (tmp != 0) begin
                k++;
                tmp = tmp >> 1;
            end
            lat = 3 + (2 * W + 1) * (1 + k + $countones(e)) + k;
        end
    endfunction

    // Leaves the bench #1 after the edge that accepted start (cycle 2).
    task automatic launch(input int unsigned b, input int unsigned e, input int unsigned m);
        @(negedge clk);
        bus.base     = W'(b);
        bus.exponent = W'(e);
        bus.modulus  = W'(m);
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycle numbering counts the start cycle as 1; returns at the done cycle.
    task automatic wait_done(input bit disturb, output int unsigned cyc);
        cyc = 2;
        while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
            if (disturb) begin
                bus.start    = 1'($urandom % 2);
                bus.base     = W'($urandom);
                bus.exponent = W'($urandom);
                bus.modulus  = W'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    task automatic run(input string tag, input int unsigned b, input int unsigned e,
                       input int unsigned m, input bit disturb);
        int unsigned res;
        bit          er;
        int unsigned lat;
        int unsigned cyc;
        ref_model(b, e, m, res, er, lat);
        launch(b, e, m);
        check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_err_cleared"}, 32'(bus.err), 32'd0);
        wait_done(disturb, cyc);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, 32'(bus.result), res);
        check({tag, "_err"}, 32'(bus.err), 32'(er));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_width"}, 32'(bus.done), 32'd0);
        check({tag, "_result_held"}, 32'(bus.result), res);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned seen;
        int unsigned rb, re, rm;

        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        reset = 1'b0;

        run("encrypt", 4, 3, 33, 1'b0);
        run("decrypt", 31, 7, 33, 1'b0);
        run("exp13", 7, 13, 33, 1'b0);
        run("base_ge_n", 40, 1, 33, 1'b0);
        run("mod0", 9, 5, 0, 1'b0);
        run("mod1", 9, 5, 1, 1'b0);
        run("exp0", 9, 0, 33, 1'b0);
        run("base0", 0, 5, 33, 1'b0);
        run("max_ops", 255, 255, 255, 1'b0);
        run("max_exp", 200, 255, 251, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rb = $urandom % 256;
            re = $urandom % 256;
            case ($urandom % 8)
                0:       rm = 0;
                1:       rm = 1;
                default: rm = $urandom_range(2, 255);
            endcase
            run($sformatf("rand%0d", i), rb, re, rm, 1'b0);
        end

        run("busy_disturb", 7, 13, 33, 1'b1);

        // start raised during DONE is ignored, then taken in the next IDLE
        launch(4, 3, 33);
        wait_done(1'b0, cyc);
        check("pre_done_result", 32'(bus.result), 32'd31);
        bus.base     = 8'd31;
        bus.exponent = 8'd7;
        bus.modulus  = 8'd33;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_done_busy", 32'(bus.busy), 32'd0);
        check("start_in_done_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_next_idle_busy", 32'(bus.busy), 32'd1);
        wait_done(1'b0, cyc);
        check("start_next_idle_latency", cyc, 32'd125);
        check("start_next_idle_result", 32'(bus.result), 32'd4);
        @(posedge clk);
        #1;

        // reset during the first MUL_A (cycles 21..37 for exponent 13)
        launch(7, 13, 33);
        repeat (23) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("abort_no_activity", seen, 32'd0);
        run("after_abort", 7, 13, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
